codeword_deserializer: RTL and testbench
========================================

CODEWORD_DESERIALIZER -- requirements
Module: codeword_deserializer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of idle cycles between accepted beats of one frame (legal range 2..1023).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port col_in, input, 7 bits: one Hamming(7,4) column codeword per beat.
REQ-005 SHALL have port col_valid, input, 1 bit: col_in and sof are valid.
REQ-006 SHALL have port sof, input, 1 bit: this beat is the first column of a frame.
REQ-007 SHALL have port col_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port frame_out, output, 105 bits: assembled frame for the two-bit decoder's encoded_data input.
REQ-009 SHALL have port frame_valid, output, 1 bit: frame_out holds a complete frame.
REQ-010 SHALL have port frame_ready, input, 1 bit: the consumer takes frame_out this cycle.
REQ-011 SHALL have port beat_cnt, output, 4 bits: number of beats collected in the current partial frame (0..14).
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a partial frame or a stray beat is discarded.

Function
REQ-013 SHALL accept a beat when col_valid and col_ready are both 1 in the same cycle.
REQ-014 SHALL implement states IDLE (beat_cnt=0) and COLLECT (beat_cnt 1..14).
REQ-015 SHALL, in IDLE, accept a sof=1 beat as beat 0 and go to COLLECT; a sof=0 beat is accepted, dropped, and pulses frame_err.
REQ-016 SHALL, in COLLECT, treat a sof=1 beat as resync: discard the partial frame, pulse frame_err, and store the beat as beat 0 (beat_cnt=1).
REQ-017 SHALL place beat k (k=0..14) in frame_out bits [(14-k)*7+6 : (14-k)*7]: beat 0 at [104:98], beat 14 at [6:0].
REQ-018 SHALL hold assembly and output in separate registers, so collection of the next frame proceeds while frame_out is held.
REQ-019 SHALL, on acceptance of beat 14, load the output register and set frame_valid the next cycle (1-cycle latency), set beat_cnt=0, and return to IDLE.
REQ-020 SHALL keep frame_valid and frame_out stable until the cycle in which frame_valid and frame_ready are both 1, clearing frame_valid after that cycle unless a new frame loads in the same cycle.
REQ-021 SHALL drive col_ready=0 only when beat_cnt=14, frame_valid=1 and frame_ready=0; otherwise col_ready=1, giving one beat per cycle sustained throughput.
REQ-022 SHALL, when beat 14 is accepted in the same cycle as an output handshake, replace frame_out with the new frame with frame_valid remaining 1.
REQ-023 SHALL leave frame_out contents unchanged when frame_valid is 0.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state IDLE, beat_cnt=0, frame_valid=0, frame_err=0, frame_out=0, assembly register=0, timeout counter=0; col_ready SHALL be 1 while rst_n=1 and the REQ-021 condition is false.
REQ-025 SHALL discard any partial or held frame on reset without a frame_err pulse.

Configuration
REQ-026 SHALL, with macro DESER_TIMEOUT_EN defined, count consecutive cycles in COLLECT without an accepted beat, and on reaching TIMEOUT_CYCLES discard the partial frame, pulse frame_err, and return to IDLE; the counter clears on every accepted beat and in IDLE.
REQ-027 SHALL, without DESER_TIMEOUT_EN, contain no timeout counter, ignore TIMEOUT_CYCLES, and hold a partial frame indefinitely.

Verification
REQ-028 SHALL cover: 15 back-to-back beats, sof on beat 0, col_in=k+1 for beat k, frame_ready=1 -> frame_valid one cycle after beat 14; frame_out[104:98]=7'h01 and frame_out[6:0]=7'h0F.
REQ-029 SHALL cover: sof=1 at beat 6 of a partial frame -> frame_err pulse, beat_cnt=1, and the next 14 beats complete a frame whose bits [104:98] equal that sof beat.
REQ-030 SHALL cover: frame_ready=0 with frame_valid=1 and beat_cnt=14 -> col_ready=0; frame_ready raised -> same-cycle beat accepted and frame_out replaced, frame_valid stays 1.
REQ-031 SHALL cover: beat with sof=0 in IDLE -> accepted, frame_err pulse, beat_cnt remains 0.
REQ-032 SHALL cover (DESER_TIMEOUT_EN, TIMEOUT_CYCLES=8): 5 beats then col_valid=0 for 8 cycles -> frame_err pulse, beat_cnt=0; without the macro -> beat_cnt holds 5 after 100 idle cycles.
REQ-033 SHALL cover: rst_n low asserted after beat 9 -> frame_valid=0, beat_cnt=0 asynchronously, no frame_err pulse.

Source files
------------

// File: rtl/codeword_deserializer.sv
// Column-to-frame deserializer: gathers 15 Hamming(7,4) column codewords into
// one 105-bit frame for the two-bit decoder, with a separate output register.
// Ports: clk, rst_n (async low); col_in/col_valid/sof/col_ready (beat input);
//        frame_out/frame_valid/frame_ready (frame output); beat_cnt, frame_err.
// Optional: define DESER_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES
//           idle cycles in COLLECT.
`timescale 1ns/1ps

module codeword_deserializer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [6:0]   col_in,
    input  logic         col_valid,
    input  logic         sof,
    output logic         col_ready,
    output logic [104:0] frame_out,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic [3:0]   beat_cnt,
    output logic         frame_err
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t         state_q, state_d;
    logic [3:0]     beat_cnt_q, beat_cnt_d;
    // Beats 0..13 are shifted in here; beat 14 goes straight to frame_q.
    logic [97:0]    asm_q, asm_d;
    logic [104:0]   frame_q, frame_d;
    logic           frame_valid_q, frame_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           accept;
    logic           out_fire;

`ifdef DESER_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0]     tmo_q, tmo_d;
`else
    logic           unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign accept   = col_valid && col_ready;
    assign out_fire = frame_valid_q && frame_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            asm_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            asm_q         <= asm_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

`ifdef DESER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        asm_d         = asm_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        frame_err_d   = 1'b0;

        if (out_fire) frame_valid_d = 1'b0;

        if (accept) begin
            if (sof) begin
                // Start or resync; a partial frame in progress is an error.
                frame_err_d = (state_q == COLLECT);
                asm_d       = {91'b0, col_in};
                beat_cnt_d  = 4'd1;
                state_d     = COLLECT;
            end else if (state_q == IDLE) begin
                frame_err_d = 1'b1;
            end else if (beat_cnt_q == 4'd14) begin
                frame_d       = {asm_q, col_in};
                frame_valid_d = 1'b1;
                beat_cnt_d    = '0;
                state_d       = IDLE;
            end else begin
                asm_d      = {asm_q[90:0], col_in};
                beat_cnt_d = beat_cnt_q + 4'd1;
            end
        end

`ifdef DESER_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == COLLECT && !accept) begin
            if (tmo_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                beat_cnt_d  = '0;
                state_d     = IDLE;
            end else begin
                tmo_d = tmo_q + 10'd1;
            end
        end
`endif
    end

    // Output logic
    always_comb begin
        // Only stall when the last beat would overwrite an unread frame.
        col_ready   = !(beat_cnt_q == 4'd14 && frame_valid_q && !frame_ready);
        frame_out   = frame_q;
        frame_valid = frame_valid_q;
        beat_cnt    = beat_cnt_q;
        frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_codeword_deserializer.sv
// Self-checking bench for codeword_deserializer: vector table, scoreboard
// of expected frames, and hand-written stall, timeout and reset sequences.
`timescale 1ns/1ps

module tb_codeword_deserializer;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   col_in = '0;
    logic         col_valid = 1'b0;
    logic         sof = 1'b0;
    logic         col_ready;
    logic [104:0] frame_out;
    logic         frame_valid;
    logic         frame_ready = 1'b0;
    logic [3:0]   beat_cnt;
    logic         frame_err;

    always #5 clk = ~clk;

    codeword_deserializer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_in      (col_in),
        .col_valid   (col_valid),
        .sof         (sof),
        .col_ready   (col_ready),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .beat_cnt    (beat_cnt),
        .frame_err   (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int           m_cnt = 0;
    logic         m_fv = 1'b0;
    int           m_to = 0;
    logic [6:0]   m_beats [15];
    logic [104:0] q_exp [$];

    typedef struct {
        logic [6:0] col;
        logic       s;
        logic [3:0] exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [6:0] col, input logic s,
                        input logic v, input logic fr);
        logic         rdy;
        logic         acc;
        logic         n_err;
        logic [104:0] f;
        col_in      = col;
        sof         = s;
        col_valid   = v;
        frame_ready = fr;
        @(negedge clk);
        rdy = !(m_cnt == 14 && m_fv && !fr);
        chk("col_ready", 128'(col_ready), 128'(rdy));
        if (m_fv && fr) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: got empty queue required entry");
            end else begin
                f = q_exp.pop_front();
                chk("frame_out", 128'(frame_out), 128'(f));
            end
            m_fv = 1'b0;
        end
        acc   = v && rdy;
        n_err = 1'b0;
        if (acc) begin
            m_to = 0;
            if (s) begin
                n_err      = (m_cnt != 0);
                m_beats[0] = col;
                m_cnt      = 1;
            end else if (m_cnt == 0) begin
                n_err = 1'b1;
            end else begin
                m_beats[m_cnt] = col;
                if (m_cnt == 14) begin
                    f = '0;
                    for (int k = 0; k < 15; k++)
                        f[(14-k)*7 +: 7] = m_beats[k];
                    q_exp.push_back(f);
                    m_fv  = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
`ifdef DESER_TIMEOUT_EN
        else if (m_cnt != 0) begin
            m_to++;
            if (m_to == TO) begin
                n_err = 1'b1;
                m_cnt = 0;
                m_to  = 0;
            end
        end
`endif
        @(posedge clk);
        #1;
        chk("beat_cnt", 128'(beat_cnt), 128'(m_cnt));
        chk("frame_err", 128'(frame_err), 128'(n_err));
        chk("frame_valid", 128'(frame_valid), 128'(m_fv));
    endtask

    initial begin
        // Vector table: stray beat, start, resync at beat 6, full frame.
        tbl[0] = '{7'h55, 1'b0, 4'd0, 1'b1};
        tbl[1] = '{7'h11, 1'b1, 4'd1, 1'b0};
        for (int i = 2; i <= 6; i++)
            tbl[i] = '{7'(i + 16), 1'b0, 4'(i), 1'b0};
        tbl[7] = '{7'h2A, 1'b1, 4'd1, 1'b1};
        for (int i = 8; i <= 21; i++)
            tbl[i] = '{7'(i + 48), 1'b0, (i == 21) ? 4'd0 : 4'(i - 6), 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_beat_cnt", 128'(beat_cnt), 128'(0));
        chk("rst_frame_valid", 128'(frame_valid), 128'(0));
        chk("rst_frame_err", 128'(frame_err), 128'(0));
        chk("rst_col_ready", 128'(col_ready), 128'(1));
        chk("rst_frame_out", 128'(frame_out), 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].col, tbl[i].s, 1'b1, 1'b1);
            chk("tbl_cnt", 128'(beat_cnt), 128'(tbl[i].exp_cnt));
            chk("tbl_err", 128'(frame_err), 128'(tbl[i].exp_err));
        end
        chk("resync_top", 128'(frame_out[104:98]), 128'(7'h2A));
        chk("resync_low", 128'(frame_out[6:0]), 128'(7'h45));

        // Back-to-back frame, col_in = k+1
        for (int k = 0; k < 15; k++)
            step(7'(k + 1), k == 0, 1'b1, 1'b1);
        chk("b2b_valid", 128'(frame_valid), 128'(1));
        chk("b2b_top", 128'(frame_out[104:98]), 128'(7'h01));
        chk("b2b_low", 128'(frame_out[6:0]), 128'(7'h0F));

        // Backpressure on the last beat, then same-cycle replace
        for (int k = 0; k < 14; k++)
            step(7'(k + 64), k == 0, 1'b1, 1'b0);
        step(7'h7E, 1'b0, 1'b1, 1'b0);
        chk("stall_ready", 128'(col_ready), 128'(0));
        chk("stall_cnt", 128'(beat_cnt), 128'(14));
        step(7'h7F, 1'b0, 1'b1, 1'b1);
        chk("replace_valid", 128'(frame_valid), 128'(1));
        chk("replace_low", 128'(frame_out[6:0]), 128'(7'h7F));
        chk("replace_top", 128'(frame_out[104:98]), 128'(7'h40));
        step(7'h00, 1'b0, 1'b0, 1'b1);

        // Idle gap inside a partial frame
        for (int k = 0; k < 5; k++)
            step(7'(k + 96), k == 0, 1'b1, 1'b1);
`ifdef DESER_TIMEOUT_EN
        for (int i = 0; i < TO; i++)
            step(7'h00, 1'b0, 1'b0, 1'b1);
        chk("timeout_err", 128'(frame_err), 128'(1));
        chk("timeout_cnt", 128'(beat_cnt), 128'(0));
`else
        for (int i = 0; i < 100; i++)
            step(7'h00, 1'b0, 1'b0, 1'b1);
        chk("hold_cnt", 128'(beat_cnt), 128'(5));
`endif

        // Held frame plus 10-beat partial, then async reset mid-cycle
        for (int k = 0; k < 15; k++)
            step(7'(k + 80), k == 0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++)
            step(7'(k + 112), k == 0, 1'b1, 1'b0);
        chk("pre_rst_cnt", 128'(beat_cnt), 128'(10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 128'(beat_cnt), 128'(0));
        chk("arst_valid", 128'(frame_valid), 128'(0));
        chk("arst_err", 128'(frame_err), 128'(0));
        chk("arst_ready", 128'(col_ready), 128'(1));
        chk("arst_frame", 128'(frame_out), 128'(0));
        m_cnt = 0;
        m_fv  = 1'b0;
        m_to  = 0;
        q_exp.delete();
        @(posedge clk);
        #1;
        chk("arst_err_hold", 128'(frame_err), 128'(0));
        rst_n = 1'b1;
        step(7'h00, 1'b0, 1'b0, 1'b1);
        step(7'h33, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
